// File: rtl/obstacle_pkg.sv
// Shared geometry, LFSR constants and small helpers for the obstacle engine.
package obstacle_pkg;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned OBS_W     = 8;
    localparam int unsigned OBS_H     = 16;
    localparam int unsigned DINO_X    = 20;
    localparam int unsigned DINO_W    = 8;
    localparam int unsigned GROUND_Y  = 110;
    localparam int unsigned NUM_SLOTS = 2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3 feed back
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [7:0]  SPAWN_X    = 8'(SCREEN_W - 1);
    localparam logic [8:0]  HIT_X_LO   = 9'(DINO_X);
    localparam logic [8:0]  HIT_X_HI   = 9'(DINO_X + DINO_W);
    localparam logic [8:0]  OBS_W9     = 9'(OBS_W);
    localparam logic [15:0] HIT_Y_MIN  = 16'(GROUND_Y - OBS_H);
    localparam logic [15:0] AIRBORNE_Y = 16'h8000;

    // Next Fibonacci LFSR state: shift left, XOR of tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // Scroll speed from score bits [7:4]: 1 + min(nibble, 3).
    function automatic logic [2:0] speed_for(input logic [3:0] nib);
        if (nib[3:2] != 2'b00) begin
            return 3'd4;
        end else begin
            return 3'd1 + {1'b0, nib[1:0]};
        end
    endfunction

endpackage

// File: rtl/obstacle_engine_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to randomise obstacle spacing.
module lfsr8
    import obstacle_pkg::*;
(
    input  logic       Clock,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] value_r;

    // Advance every cycle; an all-zero state (unreachable normally) reseeds.
    always_ff @(posedge Clock) begin
        if (reset) begin
            value_r <= LFSR_SEED;
        end else if (value_r == 8'd0) begin
            value_r <= LFSR_SEED;
        end else begin
            value_r <= lfsr_next(value_r);
        end
    end

    assign value = value_r;

endmodule

// File: rtl/obstacle_engine.sv
// Scrolls two obstacle slots, requests/loads spawns, scores and detects collisions.
module obstacle_engine
    import obstacle_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 25000000,
    parameter int unsigned SCROLL_HZ       = 60,
    parameter int unsigned MIN_GAP         = 40
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        reset_game,
    input  logic        ld_game,
    input  logic        calc_jump,
    input  logic        create_obs,
    input  logic        ld_pause,
    input  logic [15:0] height,
    output logic        gen,
    output logic        kill,
    output logic [7:0]  obs0_x,
    output logic [7:0]  obs1_x,
    output logic        obs0_valid,
    output logic        obs1_valid,
    output logic [15:0] score,
    output logic [2:0]  speed
);

    localparam int unsigned TICK_MAX = CLOCK_FREQUENCY / SCROLL_HZ - 1;
    localparam int unsigned TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_MAX);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [7:0]        GAP_INIT    = 8'(MIN_GAP);

    logic [TICK_W-1:0]               tick_r, tick_nx_s;
    logic [7:0]                      gap_r, gap_nx_s;
    logic [NUM_SLOTS-1:0][7:0]       x_r, x_nx_s;
    logic [NUM_SLOTS-1:0]            valid_r, valid_nx_s;
    logic [NUM_SLOTS-1:0]            load_sel_s, overlap_s;
    logic                            gen_r, gen_nx_s, kill_r, kill_nx_s;
    logic [15:0]                     score_r, score_nx_s;
    logic [16:0]                     score_sum_s;
    logic [2:0]                      speed_r;
    logic [1:0]                      retire_cnt_s;
    logic [7:0]                      lfsr_s;
    logic [1:0]                      lfsr_unused_s;
    logic                            active_s, run_s, live_s, step_s, load_s;

    lfsr8 u_lfsr (
        .Clock (Clock),
        .reset (reset),
        .value (lfsr_s)
    );

    // Only the low six LFSR bits take part in the gap draw.
    assign lfsr_unused_s = lfsr_s[7:6];

    assign active_s = ld_game | calc_jump | create_obs;
    assign run_s    = active_s & ~ld_pause;
    assign live_s   = run_s & ~kill_r;
    assign step_s   = live_s & (tick_r == '0);
    assign load_s   = live_s & gen_r & create_obs;

    // Pick the lowest-index slot that is free at the start of this cycle.
    always_comb begin
        logic found_v;
        found_v    = 1'b0;
        load_sel_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!valid_r[i] && !found_v) begin
                load_sel_s[i] = 1'b1;
                found_v       = 1'b1;
            end else begin
                load_sel_s[i] = 1'b0;
            end
        end
    end

    // Per-slot load/step/retire and collision overlap.
    always_comb begin
        x_nx_s       = x_r;
        valid_nx_s   = valid_r;
        retire_cnt_s = 2'd0;
        overlap_s    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (load_s && load_sel_s[i]) begin
                x_nx_s[i]     = SPAWN_X;
                valid_nx_s[i] = 1'b1;
            end else if (step_s && valid_r[i]) begin
                if (x_r[i] < {5'd0, speed_r}) begin
                    valid_nx_s[i] = 1'b0;
                    retire_cnt_s  = retire_cnt_s + 2'd1;
                end else begin
                    x_nx_s[i] = x_r[i] - {5'd0, speed_r};
                end
            end else begin
                x_nx_s[i] = x_r[i];
            end
            // Heights at or above 16'h8000 are an underflowed jump, i.e. airborne.
            overlap_s[i] = valid_r[i]
                         & ({1'b0, x_r[i]} < HIT_X_HI)
                         & (({1'b0, x_r[i]} + OBS_W9) > HIT_X_LO)
                         & (height > HIT_Y_MIN)
                         & (height < AIRBORNE_Y);
        end
    end

    // Tick, gap, spawn request, score and kill next-state.
    always_comb begin
        tick_nx_s   = tick_r;
        gap_nx_s    = gap_r;
        gen_nx_s    = gen_r;
        score_sum_s = {1'b0, score_r} + {15'd0, retire_cnt_s};
        score_nx_s  = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        kill_nx_s   = kill_r | (run_s & (|overlap_s));
        if (run_s) begin
            tick_nx_s = (tick_r == '0) ? TICK_RELOAD : (tick_r - TICK_ONE);
        end else begin
            tick_nx_s = tick_r;
        end
        if (load_s) begin
            gap_nx_s = GAP_INIT + {2'b00, lfsr_s[5:0]};
        end else if (step_s && (gap_r != 8'd0)) begin
            gap_nx_s = gap_r - 8'd1;
        end else begin
            gap_nx_s = gap_r;
        end
        if (load_s) begin
            gen_nx_s = 1'b0;
        end else if (live_s && !gen_r && (gap_nx_s == 8'd0) && (|(~valid_r))) begin
            gen_nx_s = 1'b1;
        end else begin
            gen_nx_s = gen_r;
        end
    end

    // State registers; reset_game clears everything the LFSR aside.
    always_ff @(posedge Clock) begin
        if (reset || reset_game) begin
            tick_r  <= TICK_RELOAD;
            gap_r   <= GAP_INIT;
            x_r     <= '0;
            valid_r <= '0;
            gen_r   <= 1'b0;
            kill_r  <= 1'b0;
            score_r <= 16'd0;
            speed_r <= 3'd1;
        end else begin
            tick_r  <= tick_nx_s;
            gap_r   <= gap_nx_s;
            x_r     <= x_nx_s;
            valid_r <= valid_nx_s;
            gen_r   <= gen_nx_s;
            kill_r  <= kill_nx_s;
            score_r <= score_nx_s;
            speed_r <= speed_for(score_r[7:4]);
        end
    end

    assign gen        = gen_r;
    assign kill       = kill_r;
    assign obs0_x     = x_r[0];
    assign obs1_x     = x_r[1];
    assign obs0_valid = valid_r[0];
    assign obs1_valid = valid_r[1];
    assign score      = score_r;
    assign speed      = speed_r;

endmodule

// File: tb/tb_obstacle_engine.sv
// Self-checking bench for obstacle_engine (fast tick: 10 cycles per step, MIN_GAP=2).
`timescale 1ns/1ps
module tb_obstacle_engine;

    logic        Clock = 1'b0;
    logic        reset = 1'b1, reset_game = 1'b0, ld_game = 1'b0, calc_jump = 1'b0;
    logic        create_obs = 1'b0, ld_pause = 1'b0;
    logic [15:0] height = 16'd50;
    logic        gen, kill, obs0_valid, obs1_valid;
    logic [7:0]  obs0_x, obs1_x;
    logic [15:0] score;
    logic [2:0]  speed;

    obstacle_engine #(.CLOCK_FREQUENCY(600), .SCROLL_HZ(60), .MIN_GAP(2)) dut (
        .Clock(Clock), .reset(reset), .reset_game(reset_game), .ld_game(ld_game),
        .calc_jump(calc_jump), .create_obs(create_obs), .ld_pause(ld_pause),
        .height(height), .gen(gen), .kill(kill), .obs0_x(obs0_x), .obs1_x(obs1_x),
        .obs0_valid(obs0_valid), .obs1_valid(obs1_valid), .score(score), .speed(speed)
    );

    always #5 Clock = ~Clock;

    typedef enum int {F_X0, F_V0, F_X1, F_V1, F_GEN, F_KILL, F_SCORE, F_SPEED} field_e;
    typedef struct { string name; field_e fld; logic [15:0] want; } exp_t;
    typedef struct { string name; logic [7:0] x; logic [15:0] h; logic k; } coll_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    auto_spawn = 1'b0;

    function automatic logic [15:0] field_val(field_e f);
        case (f)
            F_X0:    return {8'd0, obs0_x};
            F_V0:    return {15'd0, obs0_valid};
            F_X1:    return {8'd0, obs1_x};
            F_V1:    return {15'd0, obs1_valid};
            F_GEN:   return {15'd0, gen};
            F_KILL:  return {15'd0, kill};
            F_SCORE: return score;
            F_SPEED: return {13'd0, speed};
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic sb_expect(input string name, input field_e f, input logic [15:0] w);
        exp_t e;
        e.name = name; e.fld = f; e.want = w;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] got;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = field_val(e.fld);
            n_checks++;
            if (got === e.want) n_pass++;
            else $display("FAIL %s: got %0d, want %0d", e.name, got, e.want);
        end
    endtask

    task automatic check_bool(input string name, input bit ok);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: condition false, required true", name);
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
        drain();
        if (auto_spawn) create_obs = gen;
    endtask

    task automatic expect_reset_vals(input string tag);
        sb_expect({tag, "_x0"}, F_X0, 16'd0);    sb_expect({tag, "_v0"}, F_V0, 16'd0);
        sb_expect({tag, "_x1"}, F_X1, 16'd0);    sb_expect({tag, "_v1"}, F_V1, 16'd0);
        sb_expect({tag, "_gen"}, F_GEN, 16'd0);  sb_expect({tag, "_kill"}, F_KILL, 16'd0);
        sb_expect({tag, "_score"}, F_SCORE, 16'd0); sb_expect({tag, "_speed"}, F_SPEED, 16'd1);
    endtask

    task automatic pulse_reset_game();
        create_obs = 1'b0;
        reset_game = 1'b1;
        expect_reset_vals("rg");
        tick();
        reset_game = 1'b0;
    endtask

    task automatic wait_gen(input int budget);
        int k = 0;
        while (!gen && k < budget) begin tick(); k++; end
        check_bool("gen_timeout", gen == 1'b1);
    endtask

    task automatic load_one();
        wait_gen(1000);
        create_obs = 1'b1;
        tick();
        create_obs = 1'b0;
    endtask

    task automatic wait_x(input logic [7:0] target, input int budget);
        int k = 0;
        while (!(obs0_valid && obs0_x == target) && k < budget) begin tick(); k++; end
        check_bool("reach_x_timeout", obs0_valid && obs0_x == target);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        coll_t       ctab[10];
        logic [7:0]  x_hold;
        logic        g_hold;
        bit          ok;
        int          k;

        ctab[0] = '{"hit_x24",      8'd24, 16'd110,   1'b1};
        ctab[1] = '{"air_h90",      8'd20, 16'd90,    1'b0};
        ctab[2] = '{"underflow",    8'd20, 16'hFFF0,  1'b0};
        ctab[3] = '{"miss_x28",     8'd28, 16'd110,   1'b0};
        ctab[4] = '{"hit_x27",      8'd27, 16'd110,   1'b1};
        ctab[5] = '{"hit_x13",      8'd13, 16'd110,   1'b1};
        ctab[6] = '{"miss_x12",     8'd12, 16'd110,   1'b0};
        ctab[7] = '{"hit_h95",      8'd20, 16'd95,    1'b1};
        ctab[8] = '{"air_h94",      8'd20, 16'd94,    1'b0};
        ctab[9] = '{"hit_h7fff",    8'd20, 16'h7FFF,  1'b1};

        // Reset state
        tick();
        expect_reset_vals("reset");
        tick();
        reset = 1'b0;

        // Tick and spawn: gap 2 steps of 10 cycles -> gen on edge 20
        ld_game = 1'b1;
        repeat (18) tick();
        sb_expect("gen_before_20", F_GEN, 16'd0);
        tick();
        sb_expect("gen_at_20", F_GEN, 16'd1);
        tick();
        create_obs = 1'b1;
        sb_expect("load_x0", F_X0, 16'd159); sb_expect("load_v0", F_V0, 16'd1);
        sb_expect("load_gen", F_GEN, 16'd0);
        tick();
        sb_expect("second_create_v1", F_V1, 16'd0); sb_expect("second_create_x0", F_X0, 16'd159);
        sb_expect("second_create_gen", F_GEN, 16'd0);
        tick();
        create_obs = 1'b0;

        // Scroll and score
        auto_spawn = 1'b1;
        k = 0;
        while (obs0_valid && k < 3000) begin tick(); k++; end
        check_bool("obs0_retire_timeout", !obs0_valid);
        sb_expect("first_score", F_SCORE, 16'd1); sb_expect("first_speed", F_SPEED, 16'd1);
        drain();
        sb_expect("speed_after_1", F_SPEED, 16'd1);
        tick();
        k = 0;
        while (score < 16'd16 && k < 40000) begin tick(); k++; end
        check_bool("score16_timeout", score >= 16'd16);
        sb_expect("score16", F_SCORE, 16'd16); sb_expect("speed_lag", F_SPEED, 16'd1);
        drain();
        sb_expect("speed2", F_SPEED, 16'd2);
        tick();
        auto_spawn = 1'b0;
        pulse_reset_game();

        // Pause mid-tick
        load_one();
        wait_x(8'd158, 30);
        repeat (3) tick();
        ld_game = 1'b0; ld_pause = 1'b1;
        x_hold = obs0_x; g_hold = gen;
        repeat (50) tick();
        sb_expect("pause_x_hold", F_X0, {8'd0, x_hold});
        sb_expect("pause_gen_hold", F_GEN, {15'd0, g_hold});
        drain();
        ld_pause = 1'b0; ld_game = 1'b1;
        repeat (5) tick();
        sb_expect("resume_no_step", F_X0, 16'd158);
        tick();
        sb_expect("resume_step", F_X0, 16'd157);
        tick();

        // Collision table
        for (int i = 0; i < 10; i++) begin
            pulse_reset_game();
            load_one();
            wait_x(ctab[i].x, 2000);
            height = ctab[i].h;
            sb_expect(ctab[i].name, F_KILL, {15'd0, ctab[i].k});
            tick();
            height = 16'd50;
            if (i == 0) begin
                x_hold = obs0_x;
                repeat (25) tick();
                sb_expect("kill_freeze_x", F_X0, {8'd0, x_hold});
                sb_expect("kill_sticky", F_KILL, 16'd1);
                drain();
            end
        end

        // Full slots: gen held until a slot retires; gap back to MIN_GAP after reset_game
        pulse_reset_game();
        repeat (18) tick();
        sb_expect("rg_gen_before_20", F_GEN, 16'd0);
        tick();
        sb_expect("rg_gen_at_20", F_GEN, 16'd1);
        tick();
        create_obs = 1'b1;
        tick();
        create_obs = 1'b0;
        load_one();
        sb_expect("full_v0", F_V0, 16'd1); sb_expect("full_v1", F_V1, 16'd1);
        drain();
        ok = 1'b1; k = 0;
        while (obs0_valid && k < 2000) begin
            if (gen) ok = 1'b0;
            tick(); k++;
        end
        check_bool("gen_held_while_full", ok);
        check_bool("full_retire_timeout", !obs0_valid);
        sb_expect("gen_same_cycle_retire", F_GEN, 16'd0);
        drain();
        sb_expect("gen_after_retire", F_GEN, 16'd1);
        tick();

        // Synchronous reset mid-spawn
        reset = 1'b1; create_obs = 1'b1;
        expect_reset_vals("srst");
        tick();
        reset = 1'b0; create_obs = 1'b0;
        sb_expect("post_srst_v0", F_V0, 16'd0); sb_expect("post_srst_gen", F_GEN, 16'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
